gpio_pwm_ctrl: RTL and testbench

Parametrised GPIO output peripheral for the RISC-V SoC. It replaces the core's fixed 8-bit direct GPIO drive with a register-mapped controller, sitting between the core's peripheral bus and the top-level pins.
- Per pin: either a static level or a glitch-free PWM waveform.
- Common programmable prescaler on clk for all PWM pins.
- Atomic set/clear/toggle writes.

---
 rtl/gpio_pwm_pkg.sv | 20 ++
 rtl/pwm_timebase.sv | 45 ++++
 rtl/gpio_pwm_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gpio_pwm_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pwm_pkg.sv
// Shared definitions for the GPIO/PWM output controller.
// Holds the word-address register map, the response data width and the
// STATUS register bit layout.
package gpio_pwm_pkg;

    localparam logic [4:0] ADDR_OUT       = 5'h00;
    localparam logic [4:0] ADDR_MODE      = 5'h01;
    localparam logic [4:0] ADDR_PRESCALE  = 5'h02;
    localparam logic [4:0] ADDR_SET       = 5'h03;
    localparam logic [4:0] ADDR_CLR       = 5'h04;
    localparam logic [4:0] ADDR_TOGGLE    = 5'h05;
    localparam logic [4:0] ADDR_STATUS    = 5'h06;
    localparam logic [4:0] ADDR_DUTY_BASE = 5'h10;

    localparam int unsigned RSP_WIDTH = 32;

    // Sticky period-boundary flag position in STATUS.
    localparam int unsigned STATUS_PERIOD_BIT = 0;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: a reloadable prescaler followed by the PWM counter.
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   prescale       prescaler reload; the prescaler counts 0..prescale
//   clr_prescale   restart the prescaler from 0 (register write)
//   tick           one-cycle strobe when the prescaler reaches prescale
//   pwm_cnt        free-running PWM counter, advances on tick
//   period_end     tick while pwm_cnt is at its maximum
module pwm_timebase #(
    parameter int unsigned PWM_WIDTH      = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      clr_prescale,
    output logic                      tick,
    output logic [PWM_WIDTH-1:0]      pwm_cnt,
    output logic                      period_end
);

    logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_WIDTH-1:0]      pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        tick       = (pre_cnt_q == prescale);
        period_end = tick && (pwm_cnt_q == {PWM_WIDTH{1'b1}});
        pre_cnt_d  = (tick || clr_prescale) ? '0 : pre_cnt_q + 1'b1;
        // Natural wrap from all-ones back to zero.
        pwm_cnt_d  = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/gpio_pwm_ctrl.sv
// Register-mapped GPIO output controller with per-pin static level or PWM.
// Ports:
//   clk, rst                       system clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_we, req_addr, req_wdata    request: write enable, word address, data
//   rsp_valid/rsp_ready            response handshake (one response per request)
//   rsp_rdata                      read data, 0 for write acknowledges
//   gpio_out                       registered pin drive
module gpio_pwm_ctrl
    import gpio_pwm_pkg::*;
#(
    parameter int unsigned NUM_PINS       = 8,
    parameter int unsigned PWM_WIDTH      = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [4:0]           req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RSP_WIDTH-1:0] rsp_rdata,
    output logic [NUM_PINS-1:0]  gpio_out
);

    logic                      accept, wr_en, rd_en;
    logic [NUM_PINS-1:0]       out_q, out_d, mode_q, mode_d, gpio_q, gpio_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      clr_prescale;
    logic                      status_q, status_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [RSP_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d, rd_data;
    logic [PWM_WIDTH-1:0]      duty_shadow_q [NUM_PINS];
    logic [PWM_WIDTH-1:0]      duty_active_q [NUM_PINS];
    logic                      tick, period_end;
    logic [PWM_WIDTH-1:0]      pwm_cnt;
    logic                      unused_sig;

    // Upper write-data bits are ignored by design; tick is folded into period_end.
    assign unused_sig = ^{tick, req_wdata};

    pwm_timebase #(
        .PWM_WIDTH      (PWM_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .prescale     (prescale_q),
        .clr_prescale (clr_prescale),
        .tick         (tick),
        .pwm_cnt      (pwm_cnt),
        .period_end   (period_end)
    );

    always_comb begin
        req_ready = !rsp_valid_q || rsp_ready;
        accept    = req_valid && req_ready;
        wr_en     = accept && req_we;
        rd_en     = accept && !req_we;
    end

    // Register writes.
    always_comb begin
        out_d        = out_q;
        mode_d       = mode_q;
        prescale_d   = prescale_q;
        clr_prescale = 1'b0;
        if (wr_en) begin
            case (req_addr)
                ADDR_OUT:      out_d  = req_wdata[NUM_PINS-1:0];
                ADDR_MODE:     mode_d = req_wdata[NUM_PINS-1:0];
                ADDR_PRESCALE: begin
                    prescale_d   = req_wdata[PRESCALE_WIDTH-1:0];
                    clr_prescale = 1'b1;
                end
                ADDR_SET:      out_d = out_q | req_wdata[NUM_PINS-1:0];
                ADDR_CLR:      out_d = out_q & ~req_wdata[NUM_PINS-1:0];
                ADDR_TOGGLE:   out_d = out_q ^ req_wdata[NUM_PINS-1:0];
                default:       ;
            endcase
        end
    end

    // A boundary in the same cycle as a STATUS read wins, so the flag stays set.
    always_comb begin
        status_d = status_q;
        if (rd_en && (req_addr == ADDR_STATUS)) status_d = 1'b0;
        if (period_end) status_d = 1'b1;
    end

    // Read mux; unmapped addresses and write-only registers read 0.
    always_comb begin
        rd_data = '0;
        case (req_addr)
            ADDR_OUT:      rd_data[NUM_PINS-1:0]       = out_q;
            ADDR_MODE:     rd_data[NUM_PINS-1:0]       = mode_q;
            ADDR_PRESCALE: rd_data[PRESCALE_WIDTH-1:0] = prescale_q;
            ADDR_STATUS:   rd_data[STATUS_PERIOD_BIT]  = status_q || period_end;
            default:       ;
        endcase
        for (int i = 0; i < NUM_PINS; i++) begin
            if (req_addr == ADDR_DUTY_BASE + 5'(i)) rd_data[PWM_WIDTH-1:0] = duty_shadow_q[i];
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_we ? '0 : rd_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        logic                 duty_wr;
        logic [PWM_WIDTH-1:0] shadow_d;

        assign duty_wr  = wr_en && (req_addr == ADDR_DUTY_BASE + 5'(i));
        // Feeding shadow_d to the active register gives write-through at a boundary.
        assign shadow_d = duty_wr ? req_wdata[PWM_WIDTH-1:0] : duty_shadow_q[i];
        assign gpio_d[i] = mode_q[i] ? (pwm_cnt < duty_active_q[i]) : out_q[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                duty_shadow_q[i] <= '0;
                duty_active_q[i] <= '0;
            end else begin
                duty_shadow_q[i] <= shadow_d;
                if (period_end) duty_active_q[i] <= shadow_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            mode_q      <= '0;
            prescale_q  <= '0;
            status_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            gpio_q      <= '0;
        end else begin
            out_q       <= out_d;
            mode_q      <= mode_d;
            prescale_q  <= prescale_d;
            status_q    <= status_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            gpio_q      <= gpio_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign gpio_out  = gpio_q;

endmodule

// File: tb/tb_gpio_pwm_ctrl.sv
// Self-checking bench for gpio_pwm_ctrl: register vector table plus directed
// sequences for latency, backpressure, PWM timing, duty shadowing and reset.
module tb_gpio_pwm_ctrl;
    import gpio_pwm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [7:0]  gpio_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_pwm_ctrl #(
        .NUM_PINS       (8),
        .PWM_WIDTH      (8),
        .PRESCALE_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .gpio_out  (gpio_out)
    );

    // Pin 0 monitor: high-run lengths and rise times, sampled on negedge.
    int unsigned cyc = 0;
    logic        prev_g = 1'b0;
    int unsigned run_len = 0;
    int unsigned high_runs[$];
    int unsigned rises[$];

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        prev_g <= gpio_out[0];
        if (gpio_out[0]) begin
            run_len <= prev_g ? run_len + 1 : 1;
            if (!prev_g) rises.push_back(cyc);
        end else if (prev_g) begin
            high_runs.push_back(run_len);
        end
    end

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        chk_gpio;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic cg, input logic [7:0] eg);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.chk_gpio = cg; v.exp_gpio = eg;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One transaction; returns at the negedge after accept with the response visible.
    task automatic bus(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("bus_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bus_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        logic [31:0] d;
        bus(1'b1, addr, data, d);
        check("wr_ack_rdata", d, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, addr, 32'd0, d);
        check(name, d, exp);
    endtask

    task automatic wait_pin(input logic level, input int bound, input string name);
        int n = 0;
        while (gpio_out[0] !== level && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (gpio_out[0] !== level) check(name, {31'b0, gpio_out[0]}, {31'b0, level});
    endtask

    task automatic wait_runs(input int nh, input int nr, input int bound);
        int n = 0;
        while ((high_runs.size() < nh || rises.size() < nr) && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (high_runs.size() < nh) check("wait_high_runs", 32'(high_runs.size()), 32'(nh));
        if (rises.size() < nr) check("wait_rises", 32'(rises.size()), 32'(nr));
    endtask

    initial begin
        logic [31:0] d;

        repeat (3) @(negedge clk);
        check("reset_gpio", {24'b0, gpio_out}, 32'h0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b0;

        // Slow prescaler first so no boundary can fire during the table.
        add(1, ADDR_PRESCALE,  32'h12345, 0, 1, 8'h00);
        add(0, ADDR_PRESCALE,  0, 32'h2345, 0, 0);
        add(0, ADDR_STATUS,    0, 32'h0, 0, 0);
        add(1, ADDR_OUT,       32'hA5, 0, 1, 8'hA5);
        add(0, ADDR_OUT,       0, 32'hA5, 0, 0);
        add(1, ADDR_SET,       32'h02, 0, 1, 8'hA7);
        add(1, ADDR_CLR,       32'h80, 0, 1, 8'h27);
        add(1, ADDR_TOGGLE,    32'h101, 0, 1, 8'h26);
        add(0, ADDR_OUT,       0, 32'h26, 0, 0);
        add(0, ADDR_SET,       0, 32'h0, 0, 0);
        add(0, ADDR_CLR,       0, 32'h0, 0, 0);
        add(0, ADDR_TOGGLE,    0, 32'h0, 0, 0);
        add(1, ADDR_MODE,      32'h1FF, 0, 1, 8'h00);
        add(0, ADDR_MODE,      0, 32'hFF, 0, 0);
        add(1, ADDR_MODE,      32'h00, 0, 1, 8'h26);
        add(1, 5'h13,          32'h1AB, 0, 0, 0);
        add(0, 5'h13,          0, 32'hAB, 0, 0);
        add(0, 5'h17,          0, 32'h0, 0, 0);
        add(1, 5'h18,          32'hFF, 0, 0, 0);
        add(0, 5'h18,          0, 32'h0, 0, 0);
        add(0, 5'h1F,          0, 32'h0, 0, 0);
        add(1, 5'h1F,          32'hFFFF, 0, 0, 0);
        add(1, 5'h07,          32'hFF, 0, 0, 0);
        add(0, ADDR_OUT,       0, 32'h26, 1, 8'h26);

        foreach (vecs[i]) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, d);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            if (vecs[i].chk_gpio) begin
                @(negedge clk);
                check($sformatf("vec%0d_gpio", i), {24'b0, gpio_out}, {24'b0, vecs[i].exp_gpio});
            end
        end

        // Write latency: unchanged at N+1, new value at N+2.
        wr(ADDR_OUT, 32'h5A);
        check("latency_n1", {24'b0, gpio_out}, 32'h26);
        @(negedge clk);
        check("latency_n2", {24'b0, gpio_out}, 32'h5A);
        wr(ADDR_OUT, 32'h26);

        // Backpressure: first response held, second request stalled.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_OUT;
        check("bp_ready_first", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_addr = 5'h13;
        check("bp_ready_stall", {31'b0, req_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_hold_rdata", rsp_rdata, 32'h26);
            check("bp_hold_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_second_valid", {31'b0, rsp_valid}, 32'd1);
        check("bp_second_rdata", rsp_rdata, 32'hAB);
        @(negedge clk);
        check("bp_drained", {31'b0, rsp_valid}, 32'd0);

        // PWM: prescale 0, duty 64, then 200 written during the high phase.
        wr(ADDR_PRESCALE, 32'h0);
        wr(5'h10, 32'd64);
        wr(ADDR_OUT, 32'h0);
        wr(ADDR_MODE, 32'h01);
        wait_pin(1'b0, 600, "pwm_wait_low");
        #1;
        high_runs.delete();
        rises.delete();
        wait_runs(0, 1, 600);
        wr(5'h10, 32'd200);
        rd_chk("duty0_shadow", 5'h10, 32'd200);
        wait_runs(2, 2, 800);
        if (high_runs.size() >= 2) begin
            check("pwm_high_64", high_runs[0], 32'd64);
            check("pwm_high_200", high_runs[1], 32'd200);
        end
        if (rises.size() >= 2) check("pwm_period", rises[1] - rises[0], 32'd256);
        check("pwm_other_pins", {24'b0, gpio_out & 8'hFE}, 32'h0);
        rd_chk("status_set", ADDR_STATUS, 32'd1);
        rd_chk("status_cleared", ADDR_STATUS, 32'd0);

        // Duty 0: pin stays low for a whole period.
        wr(5'h10, 32'd0);
        repeat (300) @(negedge clk);
        #1;
        rises.delete();
        repeat (300) @(negedge clk);
        check("duty0_no_rise", 32'(rises.size()), 32'd0);
        check("duty0_low", {31'b0, gpio_out[0]}, 32'd0);

        // Duty 255: one low cycle per period.
        wr(5'h10, 32'd255);
        wait_pin(1'b1, 600, "duty255_wait_high");
        wait_pin(1'b0, 600, "duty255_wait_low");
        high_runs.delete();
        rises.delete();
        wait_runs(1, 2, 800);
        if (high_runs.size() >= 1) check("duty255_high", high_runs[0], 32'd255);
        if (rises.size() >= 2) check("duty255_period", rises[1] - rises[0], 32'd256);

        // Reset mid-PWM with a response outstanding.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_OUT;
        @(posedge clk);
        #2;
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rst_gpio", {24'b0, gpio_out}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_chk("post_rst_out", ADDR_OUT, 32'h0);
        rd_chk("post_rst_mode", ADDR_MODE, 32'h0);
        rd_chk("post_rst_prescale", ADDR_PRESCALE, 32'h0);
        rd_chk("post_rst_duty0", 5'h10, 32'h0);
        rd_chk("post_rst_duty3", 5'h13, 32'h0);
        rd_chk("post_rst_status", ADDR_STATUS, 32'h0);
        check("post_rst_gpio", {24'b0, gpio_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
